// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolution controller: funct3 encodings,
// FSM state type, request record and the flag-to-outcome decode helpers.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned BR_XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CMP  = 2'b01,
    ST_RESP = 2'b10
  } br_state_t;

  typedef struct packed {
    logic [2:0]         funct3;
    logic [BR_XLEN-1:0] rs1;
    logic [BR_XLEN-1:0] rs2;
    logic [BR_XLEN-1:0] pc;
    logic [BR_XLEN-1:0] imm;
  } br_req_t;

  // The less-than flag is only consulted when the operands differ.
  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      F3_BEQ:          t = eq;
      F3_BNE:          t = !eq;
      F3_BLT, F3_BLTU: t = !eq && lt;
      F3_BGE, F3_BGEU: t = eq || !lt;
      default:         t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic br_illegal(input logic [2:0] f3);
    logic ill;
    ill = 1'b0;
    case (f3)
      3'b010, 3'b011: ill = 1'b1;
      default:        ill = 1'b0;
    endcase
    return ill;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Request (decode -> controller) and result (controller -> PC select)
// valid/ready channels of the branch resolution controller.
interface branch_resolve_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_imm;
  logic            res_valid;
  logic            res_ready;
  logic            res_taken;
  logic [XLEN-1:0] res_target;
  logic            res_illegal;

  modport master (
    output req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, res_ready,
    input  req_ready, res_valid, res_taken, res_target, res_illegal
  );

  modport slave (
    input  req_valid, req_funct3, req_rs1, req_rs2, req_pc, req_imm, res_ready,
    output req_ready, res_valid, res_taken, res_target, res_illegal
  );
endinterface

// File: rtl/branch_resolve_ctrl_fifo.sv
// In-order request queue (module branch_req_fifo): DEPTH entries, power of 2,
// with a synchronous clear shared by reset and flush.
module branch_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = branch_pkg::br_req_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  entry_t                 i_data,
  output entry_t                 o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is write-only-on-push; stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Sequences the shared branch comparator: queue -> operand load -> flag capture -> result.
// Optional BRANCH_STATS_EN adds saturating delivered/taken result counters.
module branch_resolve_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_ctrl_if.slave bus,
  input  logic                 flush,
  output logic [XLEN-1:0]      cmp_a,
  output logic [XLEN-1:0]      cmp_b,
  output logic                 cmp_brun,
  input  logic                 cmp_breq,
  input  logic                 cmp_brlt
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]          stat_total,
  output logic [31:0]          stat_taken
`endif
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } req_t;

  req_t            w_in;
  req_t            w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_load;
  logic            w_pop;
  logic            w_capture;
  logic            w_taken;
  br_state_t       r_state;
  br_state_t       w_next;
  logic [XLEN-1:0] r_cmp_a;
  logic [XLEN-1:0] r_cmp_b;
  logic            r_cmp_brun;
  logic            r_res_valid;
  logic            r_res_taken;
  logic            r_res_illegal;
  logic [XLEN-1:0] r_res_target;

  assign w_in = '{funct3: bus.req_funct3, rs1: bus.req_rs1, rs2: bus.req_rs2,
                  pc: bus.req_pc, imm: bus.req_imm};
  // A request presented while flushing is dropped, not queued.
  assign w_push        = bus.req_valid && !w_full && !flush;
  assign bus.req_ready = (w_count < CW'(DEPTH));

  branch_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) r_state <= ST_IDLE;
    else              r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = w_empty ? ST_IDLE : ST_CMP;
      ST_CMP:  w_next = ST_RESP;
      ST_RESP: begin
        if (bus.res_ready) w_next = w_empty ? ST_IDLE : ST_CMP;
        else               w_next = ST_RESP;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: w_load = !w_empty;
      ST_CMP: begin
        w_pop     = 1'b1;
        w_capture = 1'b1;
      end
      ST_RESP: w_load = bus.res_ready && !w_empty;
      default: w_load = 1'b0;
    endcase
  end

  // The head stays in the queue through CMP, so pc/imm/funct3 are read from it there.
  assign w_taken = br_taken(w_head.funct3, cmp_breq, cmp_brlt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp_a       <= '0;
      r_cmp_b       <= '0;
      r_cmp_brun    <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_taken   <= 1'b0;
      r_res_illegal <= 1'b0;
      r_res_target  <= '0;
    end else if (flush) begin
      r_res_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_cmp_a    <= w_head.rs1;
        r_cmp_b    <= w_head.rs2;
        r_cmp_brun <= w_head.funct3[1];
      end
      if (w_capture) begin
        r_res_taken   <= w_taken;
        r_res_illegal <= br_illegal(w_head.funct3);
        r_res_target  <= w_head.pc + (w_taken ? w_head.imm : XLEN'(32'd4));
      end
      r_res_valid <= (w_next == ST_RESP);
    end
  end

  assign cmp_a           = r_cmp_a;
  assign cmp_b           = r_cmp_b;
  assign cmp_brun        = r_cmp_brun;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_taken   = r_res_taken;
  assign bus.res_illegal = r_res_illegal;
  assign bus.res_target  = r_res_target;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_total;
  logic [31:0] r_stat_taken;
  logic        w_fire;

  assign w_fire = r_res_valid && bus.res_ready;

  // Counters ignore flush: a result handshaking in the flush cycle is delivered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_total <= 32'd0;
      r_stat_taken <= 32'd0;
    end else begin
      if (w_fire && (r_stat_total != 32'hFFFF_FFFF)) r_stat_total <= r_stat_total + 32'd1;
      if (w_fire && r_res_taken && (r_stat_taken != 32'hFFFF_FFFF))
        r_stat_taken <= r_stat_taken + 32'd1;
    end
  end

  assign stat_total = r_stat_total;
  assign stat_taken = r_stat_taken;
`endif
endmodule
